// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_pkg
// Description : Shared definitions for the serial program loader: FSM state
//               encoding, frame sync byte and the byte order of data words
//               within a frame.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_SYNC   = 4'd1,
        ST_TGT    = 4'd2,
        ST_LEN_LO = 4'd3,
        ST_LEN_HI = 4'd4,
        ST_DATA   = 4'd5,
        ST_CSUM   = 4'd6,
        ST_DONE   = 4'd7,
        ST_ERROR  = 4'd8
    } state_t;

    // First byte of every frame.
    localparam logic [7:0] c_sync_byte = 8'hA5;

    // Frame byte order: the length field and every data word arrive
    // least-significant byte first.
    localparam bit c_word_lsb_first = 1'b1;

    // Maps the n-th received byte of a word onto its byte lane in the word.
    function automatic logic [2:0] lane_pos(input logic [2:0] lane,
                                            input logic [2:0] last_lane);
        if (c_word_lsb_first) begin
            return lane;
        end
        return last_lane - lane;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prog_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : prog_word_assembler
// Description : Collects DATA_WIDTH/8 bytes into one memory word.
//               o_word_done is asserted combinationally together with the
//               strobe of the last byte of a word; o_word then already holds
//               the complete word, including that last byte.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               i_clr          - drop any partially assembled word
//               i_valid/i_byte - byte strobe and data
//               o_word         - word including the current byte
//               o_word_done    - current byte completes the word
// Revision    : 1.0 - initial release
// ============================================================================
module prog_word_assembler
    import prog_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_valid,
    input  logic [7:0]            i_byte,
    output logic [DATA_WIDTH-1:0] o_word,
    output logic                  o_word_done
);

    localparam int         c_bytes     = DATA_WIDTH / 8;
    localparam logic [2:0] c_last_lane = 3'(c_bytes - 1);

    logic [2:0]            r_lane;
    logic [DATA_WIDTH-1:0] r_word;
    logic [2:0]            w_pos;
    logic [DATA_WIDTH-1:0] w_word_next;

    always_comb begin
        w_pos       = lane_pos(r_lane, c_last_lane);
        w_word_next = r_word;
        w_word_next[{w_pos, 3'b000} +: 8] = i_byte;
    end

    assign o_word      = w_word_next;
    assign o_word_done = i_valid && (r_lane == c_last_lane);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_lane <= '0;
            r_word <= '0;
        end else if (i_valid) begin
            if (r_lane == c_last_lane) begin
                r_lane <= '0;
                r_word <= '0;
            end else begin
                r_lane <= r_lane + 3'd1;
                r_word <= w_word_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Loads program images received as byte frames into one of
//               NUM_TARGETS memories while holding the system in reset.
//               Frame: A5, target, len_lo, len_hi, N words LSB first,
//               checksum (XOR of every byte between sync and checksum).
// Ports       : clk_i, rst_i        - clock, synchronous active-high reset
//               prog_i              - programming mode enable (level)
//               rx_valid_i/rx_byte_i- received byte strobe and data
//               we_o/addr_o/wdata_o - one-hot memory write port
//               sys_rst_o           - hold-reset for the rest of the system
//               done_o/err_o        - frame accepted / frame rejected
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 12,
    parameter int NUM_TARGETS    = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   prog_i,
    input  logic                   rx_valid_i,
    input  logic [7:0]             rx_byte_i,
    output logic [NUM_TARGETS-1:0] we_o,
    output logic [ADDR_WIDTH-1:0]  addr_o,
    output logic [DATA_WIDTH-1:0]  wdata_o,
    output logic                   sys_rst_o,
    output logic                   done_o,
    output logic                   err_o
);

    localparam int          c_gap_w       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  c_num_targets = 8'(NUM_TARGETS);
    localparam logic [32:0] c_max_words   = 33'd1 << ADDR_WIDTH;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [2:0]              r_target;
    logic [15:0]             r_len;
    logic [16:0]             r_word_cnt;
    logic [ADDR_WIDTH-1:0]   r_next_addr;
    logic [7:0]              r_csum;
    logic [c_gap_w-1:0]      r_gap;

    logic [15:0]             w_len_full;
    logic                    w_last_word;
    logic                    w_gap_active;
    logic                    w_gap_expired;
    logic                    w_asm_valid;
    logic                    w_asm_clr;
    logic                    w_word_done;
    logic [DATA_WIDTH-1:0]   w_word;
    logic [NUM_TARGETS-1:0]  w_we_next;

    assign w_len_full    = {rx_byte_i, r_len[7:0]};
    assign w_last_word   = (r_word_cnt + 17'd1) == {1'b0, r_len};
    assign w_gap_active  = (r_state == ST_TGT)    || (r_state == ST_LEN_LO) ||
                           (r_state == ST_LEN_HI) || (r_state == ST_DATA)   ||
                           (r_state == ST_CSUM);
    // A byte in the expiring cycle wins over the timeout.
    assign w_gap_expired = w_gap_active && !rx_valid_i && (r_gap == c_gap_last);
    assign w_asm_valid   = prog_i && rx_valid_i && (r_state == ST_DATA);
    assign w_asm_clr     = !prog_i || (r_state != ST_DATA);

    // Target was range-checked before any data, so this stays one-hot.
    for (genvar t = 0; t < NUM_TARGETS; t++) begin : g_we
        assign w_we_next[t] = (r_target == 3'(t));
    end

    prog_word_assembler #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_asm (
        .clk         (clk_i),
        .rst         (rst_i),
        .i_clr       (w_asm_clr),
        .i_valid     (w_asm_valid),
        .i_byte      (rx_byte_i),
        .o_word      (w_word),
        .o_word_done (w_word_done)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        sys_rst_o    = (r_state != ST_IDLE) && (r_state != ST_DONE);
        done_o       = (r_state == ST_DONE);
        err_o        = (r_state == ST_ERROR);
        if (!prog_i) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   w_state_next = ST_SYNC;
                ST_SYNC:   if (rx_valid_i && (rx_byte_i == c_sync_byte))
                               w_state_next = ST_TGT;
                ST_TGT:    if (rx_valid_i)
                               w_state_next = (rx_byte_i >= c_num_targets) ? ST_ERROR : ST_LEN_LO;
                ST_LEN_LO: if (rx_valid_i) w_state_next = ST_LEN_HI;
                ST_LEN_HI: if (rx_valid_i) begin
                               if ({17'd0, w_len_full} > c_max_words)
                                   w_state_next = ST_ERROR;
                               else if (w_len_full == 16'd0)
                                   w_state_next = ST_CSUM;
                               else
                                   w_state_next = ST_DATA;
                           end
                ST_DATA:   if (w_word_done && w_last_word) w_state_next = ST_CSUM;
                ST_CSUM:   if (rx_valid_i)
                               w_state_next = (rx_byte_i == r_csum) ? ST_DONE : ST_ERROR;
                default:   w_state_next = r_state;
            endcase
            if (w_gap_expired) begin
                w_state_next = ST_ERROR;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_o        <= '0;
            addr_o      <= '0;
            wdata_o     <= '0;
            r_target    <= '0;
            r_len       <= '0;
            r_word_cnt  <= '0;
            r_next_addr <= '0;
            r_csum      <= '0;
            r_gap       <= '0;
        end else begin
            we_o <= '0;

            if (prog_i && w_gap_active && !rx_valid_i) begin
                r_gap <= r_gap + 1'b1;
            end else begin
                r_gap <= '0;
            end

            if (!prog_i || (r_state == ST_IDLE) || (r_state == ST_SYNC)) begin
                r_target    <= '0;
                r_len       <= '0;
                r_word_cnt  <= '0;
                r_next_addr <= '0;
                r_csum      <= '0;
            end else if (rx_valid_i) begin
                case (r_state)
                    ST_TGT: begin
                        r_target <= rx_byte_i[2:0];
                        r_csum   <= r_csum ^ rx_byte_i;
                    end
                    ST_LEN_LO: begin
                        r_len[7:0] <= rx_byte_i;
                        r_csum     <= r_csum ^ rx_byte_i;
                    end
                    ST_LEN_HI: begin
                        r_len  <= w_len_full;
                        r_csum <= r_csum ^ rx_byte_i;
                    end
                    ST_DATA: begin
                        r_csum <= r_csum ^ rx_byte_i;
                        if (w_word_done) begin
                            we_o        <= w_we_next;
                            addr_o      <= r_next_addr;
                            wdata_o     <= w_word;
                            r_next_addr <= r_next_addr + 1'b1;
                            r_word_cnt  <= r_word_cnt + 17'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Directed self-checking bench for prog_loader (32-bit words,
//               12-bit address, 2 targets, 100-cycle byte timeout).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int NT = 2;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          prog = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic [NT-1:0] we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          sys_rst, done, err;

    int checks = 0;
    int errors = 0;
    int onehot_bad = 0;

    logic [NT-1:0] wq[$];
    logic [AW-1:0] aq[$];
    logic [DW-1:0] dq[$];
    logic [7:0]    frame[$];

    prog_loader #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .NUM_TARGETS    (NT),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .prog_i     (prog),
        .rx_valid_i (rx_valid),
        .rx_byte_i  (rx_byte),
        .we_o       (we),
        .addr_o     (addr),
        .wdata_o    (wdata),
        .sys_rst_o  (sys_rst),
        .done_o     (done),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we != '0) begin
            wq.push_back(we);
            aq.push_back(addr);
            dq.push_back(wdata);
        end
        if ($countones(we) > 1) onehot_bad++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame();
        foreach (frame[i]) begin
            send_byte(frame[i]);
            tick(1);
        end
    endtask

    task automatic clear_log();
        wq.delete();
        aq.delete();
        dq.delete();
    endtask

    task automatic chk_write(input string tag, input int i, input logic [NT-1:0] ew,
                             input logic [AW-1:0] ea, input logic [DW-1:0] ed);
        chk({tag, "_we"},   (wq.size() > i) ? 64'(wq[i]) : 64'hx, 64'(ew));
        chk({tag, "_addr"}, (aq.size() > i) ? 64'(aq[i]) : 64'hx, 64'(ea));
        chk({tag, "_data"}, (dq.size() > i) ? 64'(dq[i]) : 64'hx, 64'(ed));
    endtask

    task automatic end_prog(input string tag);
        prog = 1'b0;
        tick(2);
        chk({tag, "_exit_done"}, 64'(done), 64'd0);
        chk({tag, "_exit_err"},  64'(err), 64'd0);
        chk({tag, "_exit_srst"}, 64'(sys_rst), 64'd0);
    endtask

    initial begin
        // Reset state
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("rst_we",    64'(we), 64'd0);
        chk("rst_addr",  64'(addr), 64'd0);
        chk("rst_wdata", 64'(wdata), 64'd0);
        chk("rst_srst",  64'(sys_rst), 64'd0);
        chk("rst_done",  64'(done), 64'd0);
        chk("rst_err",   64'(err), 64'd0);

        // Two-word frame to target 0, checksum 0x8A
        clear_log();
        prog = 1'b1;
        tick(1);
        chk("t1_srst_sync", 64'(sys_rst), 64'd1);
        frame = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
        send_frame();
        send_byte(8'h44);
        chk("t1_pulse_we",   64'(we), 64'd1);
        chk("t1_pulse_addr", 64'(addr), 64'd0);
        chk("t1_pulse_data", 64'(wdata), 64'h44332211);
        tick(1);
        chk("t1_pulse_end", 64'(we), 64'd0);
        frame = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h8A};
        send_frame();
        tick(1);
        chk("t1_nwrites", 64'(wq.size()), 64'd2);
        chk_write("t1_w0", 0, 2'b01, 12'd0, 32'h44332211);
        chk_write("t1_w1", 1, 2'b01, 12'd1, 32'h88776655);
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_err",  64'(err), 64'd0);
        chk("t1_srst", 64'(sys_rst), 64'd0);
        end_prog("t1");

        // Target out of range
        clear_log();
        prog = 1'b1;
        tick(1);
        frame = '{8'hA5, 8'h05};
        send_frame();
        tick(2);
        chk("t2_err",     64'(err), 64'd1);
        chk("t2_done",    64'(done), 64'd0);
        chk("t2_srst",    64'(sys_rst), 64'd1);
        chk("t2_nwrites", 64'(wq.size()), 64'd0);
        end_prog("t2");

        // Corrupted checksum: words stay written, frame rejected
        clear_log();
        prog = 1'b1;
        tick(1);
        frame = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                  8'h55, 8'h66, 8'h77, 8'h88, 8'h8B};
        send_frame();
        tick(1);
        chk("t3_nwrites", 64'(wq.size()), 64'd2);
        chk_write("t3_w1", 1, 2'b01, 12'd1, 32'h88776655);
        chk("t3_err",  64'(err), 64'd1);
        chk("t3_done", 64'(done), 64'd0);
        end_prog("t3");

        // Stalled frame: error exactly TO cycles after the last byte
        clear_log();
        prog = 1'b1;
        tick(1);
        frame = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h11};
        send_frame();
        send_byte(8'h22);
        tick(TO - 1);
        chk("t4_err_early", 64'(err), 64'd0);
        tick(1);
        chk("t4_err_ontime", 64'(err), 64'd1);
        chk("t4_srst",       64'(sys_rst), 64'd1);
        chk("t4_nwrites",    64'(wq.size()), 64'd0);
        end_prog("t4");

        // prog_i drops together with the byte that would complete a word
        clear_log();
        prog = 1'b1;
        tick(1);
        frame = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33};
        send_frame();
        prog = 1'b0;
        send_byte(8'h44);
        chk("t5_we_abort", 64'(we), 64'd0);
        chk("t5_srst",     64'(sys_rst), 64'd0);
        tick(2);
        chk("t5_nwrites",  64'(wq.size()), 64'd0);
        chk("t5_err",      64'(err), 64'd0);

        // Leading garbage, byte arriving on the timeout cycle, N = 0
        clear_log();
        prog = 1'b1;
        tick(1);
        frame = '{8'h00, 8'hFF};
        send_frame();
        chk("t6_garbage_err",  64'(err), 64'd0);
        chk("t6_garbage_srst", 64'(sys_rst), 64'd1);
        send_byte(8'hA5);
        send_byte(8'h00);
        tick(TO - 1);
        send_byte(8'h00);
        tick(1);
        chk("t6_race_err", 64'(err), 64'd0);
        frame = '{8'h00, 8'h00};
        send_frame();
        chk("t6_done",    64'(done), 64'd1);
        chk("t6_srst",    64'(sys_rst), 64'd0);
        chk("t6_nwrites", 64'(wq.size()), 64'd0);
        end_prog("t6");

        // Single word to target 1, checksum 0x22
        clear_log();
        prog = 1'b1;
        tick(1);
        frame = '{8'hA5, 8'h01, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        send_frame();
        chk("t7_nwrites", 64'(wq.size()), 64'd1);
        chk_write("t7_w0", 0, 2'b10, 12'd0, 32'hEFBEADDE);
        chk("t7_done", 64'(done), 64'd1);
        end_prog("t7");

        // Length 4097 exceeds a 12-bit address space
        clear_log();
        prog = 1'b1;
        tick(1);
        frame = '{8'hA5, 8'h00, 8'h01, 8'h10};
        send_frame();
        chk("t8_err",  64'(err), 64'd1);
        chk("t8_srst", 64'(sys_rst), 64'd1);

        // Reset overrides prog_i in the error state
        rst = 1'b1;
        tick(1);
        chk("t9_err",  64'(err), 64'd0);
        chk("t9_srst", 64'(sys_rst), 64'd0);
        rst = 1'b0;
        prog = 1'b0;
        tick(1);

        chk("onehot", 64'(onehot_bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning memory word width in bits (multiple of 8, 8..64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, meaning word address width.
REQ-003 SHALL have parameter NUM_TARGETS, default 2, meaning number of loadable memories (1..8).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning the maximum number of idle cycles allowed between bytes inside a frame.
REQ-005 SHALL have ports:
- clk_i  in  1  single clock.
- rst_i  in  1  reset, synchronous, active-high.
- prog_i  in  1  programming-mode enable (level).
- rx_valid_i  in  1  one-cycle byte strobe from the UART receiver.
- rx_byte_i  in  8  received byte.
- we_o  out  NUM_TARGETS  one-hot write strobe, one bit per target.
- addr_o  out  ADDR_WIDTH  word address.
- wdata_o  out  DATA_WIDTH  write data.
- sys_rst_o  out  1  active-high hold-reset for the rest of the system.
- done_o  out  1  frame loaded and checksum OK.
- err_o  out  1  frame rejected.

Function
REQ-006 SHALL accept the frame: 0xA5 sync, target byte, length low byte, length high byte (16-bit word count N), N words each sent as DATA_WIDTH/8 bytes LSB first, then one checksum byte.
REQ-007 SHALL compute the checksum as the XOR of all bytes after the sync byte, up to and excluding the checksum byte.
REQ-008 SHALL use FSM states IDLE, SYNC, TGT, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR.
REQ-009 SHALL go IDLE->SYNC when prog_i=1.
REQ-010 In SYNC, SHALL discard any byte other than 0xA5 without error.
REQ-011 SHALL advance one state per accepted byte in the order TGT, LEN_LO, LEN_HI.
REQ-012 SHALL go to ERROR from TGT when target>=NUM_TARGETS.
REQ-013 SHALL go to ERROR from LEN_HI when N>2**ADDR_WIDTH.
REQ-014 SHALL go LEN_HI->CSUM when N=0, otherwise LEN_HI->DATA.
REQ-015 In DATA, SHALL shift bytes into a word assembler; on the last byte of a word SHALL register a one-cycle we_o[target] pulse in the following cycle.
REQ-016 The write pulse SHALL be accompanied by addr_o = word index (first word at 0, +1 per word) and the assembled wdata_o.
REQ-017 After word N is written, SHALL go to CSUM.
REQ-018 In CSUM, SHALL go to DONE on a checksum match, otherwise to ERROR.
REQ-019 Words already written SHALL NOT be rolled back on a checksum error.
REQ-020 SHALL keep a byte-gap counter: reset on each rx_valid_i, counting in SYNC..CSUM excluding SYNC; reaching TIMEOUT_CYCLES SHALL force ERROR.
REQ-021 done_o=1 only in DONE; err_o=1 only in ERROR; both are sticky until prog_i=0.
REQ-022 sys_rst_o=1 in every state except IDLE and DONE.
REQ-023 When prog_i falls in any state, SHALL return to IDLE next cycle and abort any pending write; this takes priority over a byte arriving in the same cycle.
REQ-024 A byte arriving in the same cycle as a timeout SHALL be consumed and the timeout SHALL NOT fire.
REQ-025 we_o SHALL never have more than one bit set.

Reset
REQ-026 On rst_i: state IDLE, we_o=0, addr_o=0, wdata_o=0, sys_rst_o=0, done_o=0, err_o=0, counters and checksum cleared.
REQ-027 rst_i SHALL override every other input.

Structure
REQ-028 A shared package prog_loader_pkg SHALL hold the state enum, the sync constant 0xA5, and the frame byte-order definition.
REQ-029 One sub-module prog_word_assembler SHALL hold the byte-to-word shifter and the byte-lane counter.

Verification
REQ-030 prog_i=1; frame A5,00,02,00, bytes 11 22 33 44 55 66 77 88, csum -> we_o=01 at addr 0 data 0x44332211, then at addr 1 data 0x88776655, done_o=1, sys_rst_o=0.
REQ-031 Target byte 05 with NUM_TARGETS=2 -> err_o=1, no we_o pulse, sys_rst_o held at 1.
REQ-032 Correct frame with the checksum byte XOR 0x01 -> both words written, err_o=1, done_o=0.
REQ-033 Frame halted after 2 data bytes, TIMEOUT_CYCLES=100 -> err_o=1 exactly 100 cycles after the last byte.
REQ-034 prog_i dropped mid-DATA while a byte strobe arrives in the same cycle -> IDLE next cycle, no we_o pulse, sys_rst_o=0.
REQ-035 Leading garbage 00 FF before A5 and a frame with N=0 -> done_o=1 and no writes.
